// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer driving one external full_adder cell,
// LSB first, one bit pair per clock, with a one-cycle done pulse at the end.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry_q;
  logic [CW-1:0]    bit_cnt;
  logic             in_run;

  // sum_sh keeps only the bits collected so far; the last bit joins them directly into sum
  assign sum_next = {fa_s, sum_sh};
  assign in_run   = (state == RUN);

  assign fa_a   = in_run & a_sh[0];
  assign fa_b   = in_run & b_sh[0];
  assign fa_cin = in_run & carry_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= op_a;
            b_sh    <= sub ? ~op_b : op_b;
            carry_q <= sub | cin;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_sh  <= sum_next[WIDTH-1:1];
          carry_q <= fa_cout;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            sum   <= sum_next;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with a behavioural full adder attached.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       fa_a;
  logic       fa_b;
  logic       fa_cin;
  logic       fa_s;
  logic       fa_cout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sub     (sub),
    .op_a    (op_a),
    .op_b    (op_b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_s    (fa_s),
    .fa_cout (fa_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns just after the edge that ends DONE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                        input string tag);
    logic [8:0] exp;
    logic [7:0] nb;
    logic [7:0] prev_sum;
    logic       prev_cout;
    logic       overlap;
    logic       held;
    int         n;
    int         busy_cnt;
    nb  = ~b;
    exp = s ? ({1'b0, a} + {1'b0, nb} + 9'd1) : ({1'b0, a} + {1'b0, b} + {8'd0, c});
    prev_sum  = sum;
    prev_cout = cout;
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    @(posedge clk); #1;
    // scramble inputs after accept; they must have no effect
    start = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); cin = ~c; sub = ~s;
    n = 0; busy_cnt = 0; overlap = 1'b0; held = 1'b1;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (sum !== prev_sum || cout !== prev_cout) held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    overlap = busy & done;
    check({tag, "_result"},  {23'd0, cout, sum}, {23'd0, exp});
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy"},    busy_cnt, 8);
    check({tag, "_held"},    {31'd0, held}, 1);
    check({tag, "_overlap"}, {31'd0, overlap}, 0);
    $display("%s a=%02h b=%02h cin=%0b sub=%0b -> sum=%02h cout=%0b (exp %02h/%0b) edges=%0d",
             tag, a, b, c, s, sum, cout, exp[7:0], exp[8], n);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, done}, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = 8'h00; op_b = 8'h00; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_sum",  {23'd0, cout, sum}, 0);
    check("reset_fa",   {29'd0, fa_a, fa_b, fa_cin}, 0);
    $display("reset busy=%0b done=%0b sum=%02h cout=%0b", busy, done, sum, cout);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "add");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_wrap");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "add_max");
    run_op(8'h10, 8'h01, 1'b0, 1'b1, "sub");
    run_op(8'h00, 8'h01, 1'b1, 1'b1, "sub_borrow");

    // start held high through RUN and DONE must not start a second op early
    op_a = 8'h5A; op_b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    op_a = 8'h01; op_b = 8'h01;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_start_result",  {23'd0, cout, sum}, 32'h096);
    check("busy_start_latency", n, 8);
    check("busy_start_overlap", {31'd0, busy & done}, 0);
    $display("busy_start first sum=%02h cout=%0b edges=%0d", sum, cout, n);
    @(posedge clk); #1;
    check("busy_start_idle", {30'd0, busy, done}, 0);
    @(posedge clk); #1;
    check("busy_start_accept", {31'd0, busy}, 1);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_start_second", {23'd0, cout, sum}, 32'h002);
    $display("busy_start second sum=%02h cout=%0b edges=%0d", sum, cout, n);
    @(posedge clk); #1;

    // reset sampled on the 4th RUN edge aborts the op
    op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_busy", {31'd0, busy}, 0);
    check("midreset_done", {31'd0, done}, 0);
    check("midreset_sum",  {23'd0, cout, sum}, 0);
    check("midreset_fa",   {29'd0, fa_a, fa_b, fa_cin}, 0);
    $display("midreset busy=%0b done=%0b sum=%02h cout=%0b", busy, done, sum, cout);
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) n++;
    end
    check("midreset_quiet", n, 0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, "after_reset");

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int cs = 0; cs < 4; cs++)
          run_op(8'(ai * 17), 8'(bi * 17 + ai), cs[0], cs[1], "sweep");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
